dpd_poly_apply: RTL and testbench
=================================

// Module: dpd_poly_apply
// PURPOSE
//  Consumer of the 5-term magnitude basis |x|^0..|x|^4 from the magnitude block.
//  Forms complex gain G = sum_k c_k*mag_k from a double-buffered coefficient bank,
//  then outputs predistorted y = x*G. Sits between magnitude generator and DAC path.
//  Raw x is delayed internally by MAG_LAT so caller feeds the same x to both blocks.
// PARAMETERS
//  MAG_LAT  6  cycles from raw x to aligned mag_0..mag_4 at this block's inputs (>=1)
// PORTS
//  clk          in   1   single clock, all logic rising edge
//  rst          in   1   synchronous, active-high reset
//  sig_in_i     in   s20 raw sample I, full scale 1.0 = 2^19
//  sig_in_q     in   s20 raw sample Q
//  sig_in_valid in   1   qualifies sig_in_i/q
//  mag_0..mag_4 in   u20 basis magnitudes, Q1.19 (1.0 = 524288), valid MAG_LAT after x
//  coef_wr      in   1   write strobe into shadow bank
//  coef_addr    in   3   term index 0..4; 5..7 ignored
//  coef_i/coef_q in  s18 coefficient, Q3.15 (1.0 = 32768)
//  coef_commit  in   1   copy shadow bank -> active bank
//  coef_ack     out  1   1-cycle pulse, cycle after commit
//  sat_clr      in   1   clear sticky saturation flag
//  sig_out_i/q  out  s20 predistorted sample
//  sig_out_valid out 1   qualifies sig_out
//  sat_flag     out  1   sticky: G or y saturated since last clear
// BEHAVIOUR
//  Reset: all pipeline regs, delay line, valids = 0; sig_out=0, sig_out_valid=0,
//   coef_ack=0, sat_flag=0; active AND shadow banks = identity (c0=32768+j0, c1..c4=0).
//  Delay line: x, valid delayed MAG_LAT cycles -> meet mags at S1.
//  S1: 10 products mag_k*c_k.{i,q}, mag zero-extended to signed, 38b.
//  S2: sum of 5 per rail, 41b, registered.
//  S3: G = round-half-up(sum >> 17), saturate to s20 (Q2.17, 1.0=131072).
//  S4: 4 products x*G, 40b.  S5: yi=ii-qq, yq=iq+qi, 41b.
//  S6: y = round-half-up(>>17), saturate to s20 -> output register.
//  Latency: raw x to sig_out = MAG_LAT+6; valid travels in lockstep; pipeline
//   free-running, invalid slots still computed but sig_out_valid=0.
//  Commit: active bank updated at edge with coef_commit; S1 uses it from next
//   cycle. All 5 terms swap atomically; never a mixed bank within a sample.
//  Write+commit same cycle: commit copies shadow as before the write; the
//   write lands in shadow only (needs another commit). Back-to-back commits legal,
//   one ack per commit.
//  Saturation: clip to +524287 / -524288; sat_flag set on any clip in S3 or S6
//   regardless of valid; set and sat_clr same cycle -> set wins.
//  Mid-operation reset: in-flight samples dropped, coefficients back to identity.
// STRUCTURE
//  dpd_pkg: typedefs s18, s20, u20, s40; MAG_ONE=524288, COEF_ONE=32768,
//   GAIN_ONE=131072, N_TERMS=5, GAIN_SHIFT=17.
//  Sub-module cplx_mul_rnd_sat: S4-S6 (complex mult, round, saturate, clip flag);
//   reused for the S3 rounding stage helper only if widths are parameterised.
// TESTING
//  Identity: reset, x=(100000,-50000), mag_0=524287, others any -> y=(100000,-50000)
//   after MAG_LAT+6, sig_out_valid aligned.
//  Gain: c0=16384 (0.5) committed, x=(200000,0) -> y=(100000,0); coef_ack 1 cycle.
//  Cubic: c0=0, c2=32768, mag_2=262144 (0.5), x=(0,400000) -> y=(0,200000).
//  Atomic swap: stream valid samples, commit mid-stream -> outputs switch exactly
//   at one sample boundary; write+commit same cycle -> written term not active.
//  Saturation: c0=65536 (2.0), x=(400000,400000) -> y=(524287,524287), sat_flag=1
//   until sat_clr; sat_clr with concurrent clip -> flag stays 1.
//  Reset mid-stream: assert rst with valids in flight -> next cycle all outputs 0,
//   coefficients identity; coef_addr=6 write ignored.

Source files
------------

// File: rtl/dpd_pkg.sv
// Shared types and constants for the DPD polynomial gain/apply path.
// rnd_sat() is the single round-half-up / saturate-to-s20 step used for both G and y.
package dpd_pkg;
    typedef logic signed [17:0] s18_t;
    typedef logic signed [19:0] s20_t;
    typedef logic        [19:0] u20_t;
    typedef logic signed [37:0] s38_t;
    typedef logic signed [39:0] s40_t;
    typedef logic signed [40:0] s41_t;

    localparam int MAG_ONE    = 524288;
    localparam int COEF_ONE   = 32768;
    localparam int GAIN_ONE   = 131072;
    localparam int N_TERMS    = 5;
    localparam int GAIN_SHIFT = 17;

    localparam s18_t COEF_ONE_S18 = 18'sd32768;
    localparam logic signed [41:0] RND    = 42'sd65536;
    localparam logic signed [41:0] SAT_HI = 42'sd524287;
    localparam logic signed [41:0] SAT_LO = -42'sd524288;

    typedef struct packed {
        s20_t val;
        logic clip;
    } rs_t;

    // One extra bit of headroom so the rounding add cannot wrap.
    function automatic rs_t rnd_sat(input s41_t v);
        logic signed [41:0] t;
        rs_t r;
        t = v;
        t = (t + RND) >>> GAIN_SHIFT;
        if (t > SAT_HI) begin
            r.val  = 20'sh7FFFF;
            r.clip = 1'b1;
        end else if (t < SAT_LO) begin
            r.val  = 20'sh80000;
            r.clip = 1'b1;
        end else begin
            r.val  = t[19:0];
            r.clip = 1'b0;
        end
        return r;
    endfunction
endpackage

// File: rtl/cplx_mul_rnd_sat.sv
// Stages S4-S6: complex multiply x*G, combine rails, round/saturate into the output register.
// clip_o is combinational from the S6 input so the sticky flag updates with the output.
module cplx_mul_rnd_sat
    import dpd_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  s20_t xi_i,
    input  s20_t xq_i,
    input  s20_t gi_i,
    input  s20_t gq_i,
    output s20_t yi_o,
    output s20_t yq_o,
    output logic clip_o
);
    s40_t ii_q, qq_q, iq_q, qi_q, ii_d, qq_d, iq_d, qi_d;
    s41_t yi_q, yq_q, yi_d, yq_d;
    s20_t yi_out_q, yq_out_q;
    rs_t  rs_i, rs_q;

    always_comb begin
        s40_t xi40, xq40, gi40, gq40;
        s41_t a41, b41, c41, d41;
        xi40 = xi_i;
        xq40 = xq_i;
        gi40 = gi_i;
        gq40 = gq_i;
        ii_d = xi40 * gi40;
        qq_d = xq40 * gq40;
        iq_d = xi40 * gq40;
        qi_d = xq40 * gi40;
        a41  = ii_q;
        b41  = qq_q;
        c41  = iq_q;
        d41  = qi_q;
        yi_d = a41 - b41;
        yq_d = c41 + d41;
        rs_i = rnd_sat(yi_q);
        rs_q = rnd_sat(yq_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ii_q     <= '0;
            qq_q     <= '0;
            iq_q     <= '0;
            qi_q     <= '0;
            yi_q     <= '0;
            yq_q     <= '0;
            yi_out_q <= '0;
            yq_out_q <= '0;
        end else begin
            ii_q     <= ii_d;
            qq_q     <= qq_d;
            iq_q     <= iq_d;
            qi_q     <= qi_d;
            yi_q     <= yi_d;
            yq_q     <= yq_d;
            yi_out_q <= rs_i.val;
            yq_out_q <= rs_q.val;
        end
    end

    assign yi_o   = yi_out_q;
    assign yq_o   = yq_out_q;
    assign clip_o = rs_i.clip | rs_q.clip;
endmodule

// File: rtl/dpd_poly_apply.sv
// Polynomial DPD apply: G = sum c_k*|x|^k from a double-buffered bank, y = x*G.
// Raw x is delayed MAG_LAT cycles to meet the externally generated magnitude basis.
module dpd_poly_apply
    import dpd_pkg::*;
#(
    parameter int MAG_LAT = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  s20_t       sig_in_i,
    input  s20_t       sig_in_q,
    input  logic       sig_in_valid,
    input  u20_t       mag_0,
    input  u20_t       mag_1,
    input  u20_t       mag_2,
    input  u20_t       mag_3,
    input  u20_t       mag_4,
    input  logic       coef_wr,
    input  logic [2:0] coef_addr,
    input  s18_t       coef_i,
    input  s18_t       coef_q,
    input  logic       coef_commit,
    output logic       coef_ack,
    input  logic       sat_clr,
    output s20_t       sig_out_i,
    output s20_t       sig_out_q,
    output logic       sig_out_valid,
    output logic       sat_flag
);
    s20_t [MAG_LAT-1:0] xi_dly_q, xq_dly_q;
    logic [MAG_LAT-1:0] v_dly_q;
    s18_t [N_TERMS-1:0] sh_i_q, sh_q_q, ac_i_q, ac_q_q;
    s38_t [N_TERMS-1:0] pi_q, pq_q, pi_d, pq_d;
    u20_t [N_TERMS-1:0] mag;
    s20_t x1i_q, x1q_q, x2i_q, x2q_q, x3i_q, x3q_q, gi_q, gq_q;
    s41_t si_q, sq_q, si_d, sq_d;
    logic [5:0] vld_pipe;
    logic ack_q, sat_q, sat_d, clip6;
    rs_t  gi_rs, gq_rs;

    assign mag = {mag_4, mag_3, mag_2, mag_1, mag_0};

    always_comb begin
        s38_t m38, ci38, cq38;
        s41_t e41;
        pi_d = '0;
        pq_d = '0;
        si_d = '0;
        sq_d = '0;
        for (int k = 0; k < N_TERMS; k++) begin
            m38     = {18'b0, mag[k]};
            ci38    = ac_i_q[k];
            cq38    = ac_q_q[k];
            pi_d[k] = m38 * ci38;
            pq_d[k] = m38 * cq38;
            e41     = pi_q[k];
            si_d    = si_d + e41;
            e41     = pq_q[k];
            sq_d    = sq_d + e41;
        end
        gi_rs = rnd_sat(si_q);
        gq_rs = rnd_sat(sq_q);
        // Set wins over clear when both happen in the same cycle.
        sat_d = (sat_q & ~sat_clr) | gi_rs.clip | gq_rs.clip | clip6;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xi_dly_q <= '0;
            xq_dly_q <= '0;
            v_dly_q  <= '0;
            pi_q     <= '0;
            pq_q     <= '0;
            si_q     <= '0;
            sq_q     <= '0;
            gi_q     <= '0;
            gq_q     <= '0;
            x1i_q    <= '0;
            x1q_q    <= '0;
            x2i_q    <= '0;
            x2q_q    <= '0;
            x3i_q    <= '0;
            x3q_q    <= '0;
            vld_pipe <= '0;
            ack_q    <= 1'b0;
            sat_q    <= 1'b0;
            for (int k = 0; k < N_TERMS; k++) begin
                sh_i_q[k] <= (k == 0) ? COEF_ONE_S18 : '0;
                ac_i_q[k] <= (k == 0) ? COEF_ONE_S18 : '0;
            end
            sh_q_q <= '0;
            ac_q_q <= '0;
        end else begin
            for (int k = MAG_LAT - 1; k > 0; k--) begin
                xi_dly_q[k] <= xi_dly_q[k-1];
                xq_dly_q[k] <= xq_dly_q[k-1];
                v_dly_q[k]  <= v_dly_q[k-1];
            end
            xi_dly_q[0] <= sig_in_i;
            xq_dly_q[0] <= sig_in_q;
            v_dly_q[0]  <= sig_in_valid;
            pi_q     <= pi_d;
            pq_q     <= pq_d;
            x1i_q    <= xi_dly_q[MAG_LAT-1];
            x1q_q    <= xq_dly_q[MAG_LAT-1];
            si_q     <= si_d;
            sq_q     <= sq_d;
            x2i_q    <= x1i_q;
            x2q_q    <= x1q_q;
            gi_q     <= gi_rs.val;
            gq_q     <= gq_rs.val;
            x3i_q    <= x2i_q;
            x3q_q    <= x2q_q;
            vld_pipe <= {vld_pipe[4:0], v_dly_q[MAG_LAT-1]};
            ack_q    <= coef_commit;
            sat_q    <= sat_d;
            // Commit copies the pre-write shadow; a same-cycle write waits for the next commit.
            if (coef_commit) begin
                ac_i_q <= sh_i_q;
                ac_q_q <= sh_q_q;
            end
            if (coef_wr && coef_addr < 3'(N_TERMS)) begin
                sh_i_q[coef_addr] <= coef_i;
                sh_q_q[coef_addr] <= coef_q;
            end
        end
    end

    cplx_mul_rnd_sat u_mul (
        .clk    (clk),
        .rst    (rst),
        .xi_i   (x3i_q),
        .xq_i   (x3q_q),
        .gi_i   (gi_q),
        .gq_i   (gq_q),
        .yi_o   (sig_out_i),
        .yq_o   (sig_out_q),
        .clip_o (clip6)
    );

    assign sig_out_valid = vld_pipe[5];
    assign coef_ack      = ack_q;
    assign sat_flag      = sat_q;
endmodule

// File: tb/tb_dpd_poly_apply.sv
// Directed bench for dpd_poly_apply: driver pushes expected samples, monitor pops and compares.
module tb_dpd_poly_apply;
    import dpd_pkg::*;
    localparam int M = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    s20_t sig_in_i = '0, sig_in_q = '0;
    logic sig_in_valid = 1'b0;
    u20_t mag_0 = '0, mag_1 = '0, mag_2 = '0, mag_3 = '0, mag_4 = '0;
    logic coef_wr = 1'b0, coef_commit = 1'b0, sat_clr = 1'b0;
    logic [2:0] coef_addr = '0;
    s18_t coef_i = '0, coef_q = '0;
    logic coef_ack, sig_out_valid, sat_flag;
    s20_t sig_out_i, sig_out_q;

    always #5 clk = ~clk;

    dpd_poly_apply #(.MAG_LAT(M)) dut (
        .clk(clk), .rst(rst),
        .sig_in_i(sig_in_i), .sig_in_q(sig_in_q), .sig_in_valid(sig_in_valid),
        .mag_0(mag_0), .mag_1(mag_1), .mag_2(mag_2), .mag_3(mag_3), .mag_4(mag_4),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_i(coef_i), .coef_q(coef_q),
        .coef_commit(coef_commit), .coef_ack(coef_ack), .sat_clr(sat_clr),
        .sig_out_i(sig_out_i), .sig_out_q(sig_out_q), .sig_out_valid(sig_out_valid),
        .sat_flag(sat_flag)
    );

    typedef struct { int ei; int eq; int t; } exp_t;
    typedef struct { int m0; int mo; int m2; } mg_t;
    exp_t sb_q[$];
    mg_t  mag_q[$];
    exp_t e;
    int cyc_cnt = 0;
    int drv_pass = 0, drv_tot = 0, mon_pass = 0, mon_tot = 0;
    logic p_wr = 0, p_commit = 0, p_clr = 0, p_rst = 1;
    logic [2:0] p_addr = '0;
    int p_ci = 0, p_cq = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: every valid output must match the oldest expectation, with the fixed latency.
    always @(negedge clk) begin
        if (sig_out_valid) begin
            mon_tot++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_out got=(%0d,%0d) want=no valid output", sig_out_i, sig_out_q);
            end else begin
                e = sb_q.pop_front();
                if (int'(sig_out_i) == e.ei && int'(sig_out_q) == e.eq && cyc_cnt - e.t == M + 6)
                    mon_pass++;
                else
                    $display("FAIL sample got=(%0d,%0d) lat=%0d want=(%0d,%0d) lat=%0d",
                             sig_out_i, sig_out_q, cyc_cnt - e.t, e.ei, e.eq, M + 6);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        drv_tot++;
        if (got == want) drv_pass++;
        else $display("FAIL %s got=%0d want=%0d", name, got, want);
    endtask

    // One clock of stimulus; mags are replayed MAG_LAT cycles later like the magnitude block.
    task automatic cyc(input int xi, input int xq, input bit v, input int m0, input int mo,
                       input int m2, input int ei, input int eq);
        mg_t mg;
        sig_in_i     = s20_t'(xi);
        sig_in_q     = s20_t'(xq);
        sig_in_valid = v;
        coef_wr      = p_wr;
        coef_addr    = p_addr;
        coef_i       = s18_t'(p_ci);
        coef_q       = s18_t'(p_cq);
        coef_commit  = p_commit;
        sat_clr      = p_clr;
        rst          = p_rst;
        if (p_rst) sb_q.delete();
        else if (v) sb_q.push_back('{ei, eq, cyc_cnt});
        p_wr = 0; p_commit = 0; p_clr = 0; p_rst = 0;
        mag_q.push_back('{m0, mo, m2});
        mg = mag_q.pop_front();
        mag_0 = u20_t'(mg.m0);
        mag_1 = u20_t'(mg.mo);
        mag_2 = u20_t'(mg.m2);
        mag_3 = u20_t'(mg.mo);
        mag_4 = u20_t'(mg.mo);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int a, input int ci, input int cq);
        p_wr = 1; p_addr = 3'(a); p_ci = ci; p_cq = cq;
        idle();
    endtask

    task automatic commit();
        p_commit = 1;
        idle();
        chk("coef_ack_pulse", int'(coef_ack), 1);
        idle();
        chk("coef_ack_clear", int'(coef_ack), 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (sb_q.size() == 0) break;
            idle();
        end
        chk("drain_pending", sb_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i < M; i++) mag_q.push_back('{0, 0, 0});
        @(posedge clk);
        #2;
        p_rst = 1; idle();
        p_rst = 1; idle();
        chk("rst_out_i", int'(sig_out_i), 0);
        chk("rst_out_q", int'(sig_out_q), 0);
        chk("rst_valid", int'(sig_out_valid), 0);
        chk("rst_ack", int'(coef_ack), 0);
        chk("rst_sat", int'(sat_flag), 0);
        idle();

        // Identity bank: c1..c4 are zero so the other magnitudes must not matter.
        cyc(100000, -50000, 1, 524287, 300000, 300000, 100000, -50000);
        drain();

        // Gain 0.5; second sample exercises round-half-up on both signs.
        wr(0, 16384, 0);
        commit();
        cyc(200000, 0, 1, 524287, 0, 0, 100000, 0);
        cyc(-200001, 3, 1, 524287, 0, 0, -100000, 2);
        drain();

        // Cubic term only.
        wr(0, 0, 0);
        wr(2, 32768, 0);
        commit();
        cyc(0, 400000, 1, 524287, 0, 262144, 0, 200000);
        drain();

        // Write and commit together: the written c0 must not be active yet.
        p_wr = 1; p_addr = 3'd0; p_ci = 16384; p_cq = 0; p_commit = 1;
        idle();
        chk("wrcommit_ack", int'(coef_ack), 1);
        cyc(0, 400000, 1, 524287, 0, 262144, 0, 200000);
        drain();
        commit();
        cyc(0, 400000, 1, 524287, 0, 262144, 0, 400000);
        drain();

        // Atomic swap mid-stream: G goes 1.0 -> 0.5; sample n meets the bank at S1 in cycle n+M.
        wr(2, 0, 0);
        for (int n = 0; n < 12; n++) begin
            if (n == 8) p_commit = 1;
            cyc(200000, 0, 1, 524287, 0, 262144, (n > 8 - M) ? 100000 : 200000, 0);
            if (n == 8) chk("swap_ack", int'(coef_ack), 1);
        end
        drain();

        // Saturation with gain 2.0, both clip directions.
        wr(0, 65536, 0);
        commit();
        cyc(400000, 400000, 1, 524287, 0, 0, 524287, 524287);
        cyc(-400000, 400000, 1, 524287, 0, 0, -524288, 524287);
        for (int i = 0; i < 14; i++) cyc(400000, 400000, 0, 524287, 0, 0, 0, 0);
        chk("sat_set", int'(sat_flag), 1);
        p_clr = 1;
        cyc(400000, 400000, 0, 524287, 0, 0, 0, 0);
        chk("sat_clr_vs_clip", int'(sat_flag), 1);
        for (int i = 0; i < 16; i++) idle();
        chk("sat_sticky", int'(sat_flag), 1);
        p_clr = 1;
        idle();
        chk("sat_cleared", int'(sat_flag), 0);
        drain();

        // Reset with samples in flight and a pending shadow write.
        wr(0, 16384, 0);
        for (int i = 0; i < 4; i++) cyc(200000, 0, 1, 524287, 0, 0, 400000, 0);
        p_rst = 1;
        cyc(200000, 0, 1, 524287, 0, 0, 0, 0);
        chk("midrst_out_i", int'(sig_out_i), 0);
        chk("midrst_out_q", int'(sig_out_q), 0);
        chk("midrst_valid", int'(sig_out_valid), 0);
        chk("midrst_ack", int'(coef_ack), 0);
        chk("midrst_sat", int'(sat_flag), 0);
        for (int i = 0; i < 14; i++) idle();
        wr(6, 16384, 0);
        commit();
        cyc(100000, -50000, 1, 524287, 300000, 300000, 100000, -50000);
        drain();

        $display("%0d/%0d checks passed", drv_pass + mon_pass, drv_tot + mon_tot);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=no finish want=finish");
        $fatal(1);
    end
endmodule
